// File: rtl/nand_logic_seq.sv
// nand_logic_seq
// Multi-cycle 4-bit logic unit whose only datapath is one external quad
// 2-input NAND package. Each STEP cycle drives one NAND layer onto the four
// gates (one gate per bit) and latches the gate outputs into a temporary or,
// on the final layer, into the result register.

module nand_logic_seq (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic [2:0] op,
   input  logic [3:0] a,
   input  logic [3:0] b,
   output logic [3:0] gate_x,
   output logic [3:0] gate_y,
   input  logic [3:0] gate_z,
   output logic       busy,
   output logic       done,
   output logic [3:0] result
);

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_STEP = 2'd1;
   localparam logic [1:0] ST_DONE = 2'd2;

   localparam logic [2:0] OP_NAND = 3'b000;
   localparam logic [2:0] OP_AND  = 3'b001;
   localparam logic [2:0] OP_OR   = 3'b010;
   localparam logic [2:0] OP_NOR  = 3'b011;
   localparam logic [2:0] OP_XOR  = 3'b100;
   localparam logic [2:0] OP_XNOR = 3'b101;
   localparam logic [2:0] OP_NOT  = 3'b110;
   localparam logic [2:0] OP_BUF  = 3'b111;

   logic [1:0] state_q, state_d;
   logic [2:0] step_q, step_d;
   logic [2:0] op_q, op_d;
   logic [3:0] a_q, a_d;
   logic [3:0] b_q, b_d;
   logic [3:0] t1_q, t1_d;
   logic [3:0] t2_q, t2_d;
   logic [3:0] t3_q, t3_d;
   logic [3:0] result_q, result_d;

   logic [3:0] gateX;
   logic [3:0] gateY;
   logic       wrT1;
   logic       wrT2;
   logic       wrT3;
   logic       wrRes;
   logic       accept;

   // Decode the current (op, step) into the NAND layer to drive and the
   // register that captures its output; writing the result marks the last step.
   always_comb begin
      gateX = 4'h0;
      gateY = 4'h0;
      wrT1  = 1'b0;
      wrT2  = 1'b0;
      wrT3  = 1'b0;
      wrRes = 1'b0;
      if (state_q == ST_STEP) begin
         case (op_q)
            OP_NAND: begin
               gateX = a_q; gateY = b_q; wrRes = 1'b1;
            end
            OP_AND: begin
               case (step_q)
                  3'd1:    begin gateX = a_q;  gateY = b_q;  wrT1  = 1'b1; end
                  default: begin gateX = t1_q; gateY = t1_q; wrRes = 1'b1; end
               endcase
            end
            OP_OR: begin
               case (step_q)
                  3'd1:    begin gateX = a_q;  gateY = a_q;  wrT1  = 1'b1; end
                  3'd2:    begin gateX = b_q;  gateY = b_q;  wrT2  = 1'b1; end
                  default: begin gateX = t1_q; gateY = t2_q; wrRes = 1'b1; end
               endcase
            end
            OP_NOR: begin
               case (step_q)
                  3'd1:    begin gateX = a_q;  gateY = a_q;  wrT1  = 1'b1; end
                  3'd2:    begin gateX = b_q;  gateY = b_q;  wrT2  = 1'b1; end
                  3'd3:    begin gateX = t1_q; gateY = t2_q; wrT3  = 1'b1; end
                  default: begin gateX = t3_q; gateY = t3_q; wrRes = 1'b1; end
               endcase
            end
            OP_XOR: begin
               case (step_q)
                  3'd1:    begin gateX = a_q;  gateY = b_q;  wrT1  = 1'b1; end
                  3'd2:    begin gateX = a_q;  gateY = t1_q; wrT2  = 1'b1; end
                  3'd3:    begin gateX = b_q;  gateY = t1_q; wrT3  = 1'b1; end
                  default: begin gateX = t2_q; gateY = t3_q; wrRes = 1'b1; end
               endcase
            end
            OP_XNOR: begin
               case (step_q)
                  3'd1:    begin gateX = a_q;  gateY = b_q;  wrT1  = 1'b1; end
                  3'd2:    begin gateX = a_q;  gateY = t1_q; wrT2  = 1'b1; end
                  3'd3:    begin gateX = b_q;  gateY = t1_q; wrT3  = 1'b1; end
                  3'd4:    begin gateX = t2_q; gateY = t3_q; wrT1  = 1'b1; end
                  default: begin gateX = t1_q; gateY = t1_q; wrRes = 1'b1; end
               endcase
            end
            OP_NOT: begin
               gateX = a_q; gateY = a_q; wrRes = 1'b1;
            end
            OP_BUF: begin
               case (step_q)
                  3'd1:    begin gateX = a_q;  gateY = a_q;  wrT1  = 1'b1; end
                  default: begin gateX = t1_q; gateY = t1_q; wrRes = 1'b1; end
               endcase
            end
            default: begin
               gateX = 4'h0; gateY = 4'h0;
            end
         endcase
      end
   end

   // A request is taken whenever no operation is in flight, which includes
   // the DONE cycle so back-to-back operations run without an idle gap.
   assign accept = start && (state_q != ST_STEP);

   // Next-state logic: sequence the steps, latch the gate outputs, and
   // capture operands on an accepted request.
   always_comb begin
      state_d  = state_q;
      step_d   = step_q;
      op_d     = op_q;
      a_d      = a_q;
      b_d      = b_q;
      t1_d     = t1_q;
      t2_d     = t2_q;
      t3_d     = t3_q;
      result_d = result_q;
      case (state_q)
         ST_IDLE, ST_DONE: begin
            if (accept) begin
               state_d = ST_STEP;
               step_d  = 3'd1;
               op_d    = op;
               a_d     = a;
               b_d     = b;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_STEP: begin
            if (wrT1) t1_d = gate_z;
            if (wrT2) t2_d = gate_z;
            if (wrT3) t3_d = gate_z;
            if (wrRes) begin
               result_d = gate_z;
               state_d  = ST_DONE;
            end else begin
               step_d = step_q + 3'd1;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // State registers; reset aborts any operation in flight and clears the result.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= ST_IDLE;
         step_q   <= 3'd0;
         op_q     <= 3'd0;
         a_q      <= 4'h0;
         b_q      <= 4'h0;
         t1_q     <= 4'h0;
         t2_q     <= 4'h0;
         t3_q     <= 4'h0;
         result_q <= 4'h0;
      end else begin
         state_q  <= state_d;
         step_q   <= step_d;
         op_q     <= op_d;
         a_q      <= a_d;
         b_q      <= b_d;
         t1_q     <= t1_d;
         t2_q     <= t2_d;
         t3_q     <= t3_d;
         result_q <= result_d;
      end
   end

   assign gate_x = gateX;
   assign gate_y = gateY;
   assign busy   = (state_q == ST_STEP);
   assign done   = (state_q == ST_DONE);
   assign result = result_q;

endmodule
